aos_stream_bridge: RTL and testbench

Parametrised bus-to-stream bridge for the AOS accelerator: a register-addressed write/read port feeds an input FIFO drained into the core's AXI4-Stream slave. The core's AXI4-Stream master output lands in an output FIFO popped by register reads. Status and control registers expose FIFO fill levels, a sticky underflow flag, a flush, and the runtime frame width driven to the core. It replaces the fixed single-beat wrapper with buffered, back-pressured, width- and depth-generic transport.

---
 rtl/aos_stream_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_aos_stream_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aos_stream_bridge.sv
// Register-addressed bridge between a simple bus port and the AOS core's AXI4-Stream ports,
// with input/output FIFOs. Define AOS_BRIDGE_IRQ_EN to enable the output-level interrupt.
module aos_stream_bridge #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int IN_NBYTE       = 1,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                waddr_i,
    input  logic [AXI_DATA_WIDTH-1:0] wdata_i,
    input  logic [IN_NBYTE-1:0]       wkeep_i,
    input  logic                      wlast_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,
    input  logic [1:0]                raddr_i,
    input  logic                      ren_i,
    output logic [AXI_DATA_WIDTH-1:0] rdata_o,
    output logic                      rvalid_o,
    output logic [IN_NBYTE*8-1:0]     m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [IN_NBYTE-1:0]       m_axis_tkeep,
    output logic                      m_axis_tlast,
    input  logic [IN_NBYTE*8-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [IN_NBYTE-1:0]       s_axis_tkeep,
    input  logic                      s_axis_tlast,
    output logic [8:0]                frame_width_o,
    output logic                      irq_o
);
    localparam int DW = IN_NBYTE * 8;
    localparam int EW = DW + IN_NBYTE + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [EW-1:0] in_mem_q  [FIFO_DEPTH];
    logic [EW-1:0] out_mem_q [FIFO_DEPTH];
    logic [AW-1:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [AW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic          underflow_q, underflow_d;
    logic [8:0]    frame_width_q, frame_width_d;
    logic [7:0]    irq_thresh_q, irq_thresh_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic          rvalid_q;

    logic          in_full, in_empty, out_full, out_empty;
    logic          ctrl_wr, flush, rd_data;
    logic          in_push, in_pop, out_push, out_pop;
    logic [EW-1:0] in_head, out_head;
    logic [31:0]   rd_word;

    assign in_full   = (in_cnt_q == CW'(FIFO_DEPTH));
    assign in_empty  = (in_cnt_q == '0);
    assign out_full  = (out_cnt_q == CW'(FIFO_DEPTH));
    assign out_empty = (out_cnt_q == '0);
    assign in_head   = in_mem_q[in_rd_q];
    assign out_head  = out_mem_q[out_rd_q];

    assign ctrl_wr  = wvalid_i && (waddr_i == 2'd3);
    assign flush    = ctrl_wr && wdata_i[31];
    assign rd_data  = ren_i && (raddr_i == 2'd1);
    // Flush wins over every same-cycle push and pop, on both sides.
    assign in_push  = wvalid_i && (waddr_i == 2'd0) && !in_full && !flush;
    assign in_pop   = !in_empty && m_axis_tready && !flush;
    assign out_push = s_axis_tvalid && !out_full && !flush;
    assign out_pop  = rd_data && !out_empty && !flush;

    assign wready_o      = (waddr_i == 2'd0) ? !in_full : 1'b1;
    assign m_axis_tvalid = !in_empty;
    assign m_axis_tdata  = in_empty ? '0 : in_head[DW-1:0];
    assign m_axis_tkeep  = in_empty ? '0 : in_head[DW+IN_NBYTE-1:DW];
    assign m_axis_tlast  = !in_empty && in_head[EW-1];
    assign s_axis_tready = !out_full;
    assign frame_width_o = frame_width_q;
    assign rdata_o       = rdata_q;
    assign rvalid_o      = rvalid_q;

    always_ff @(posedge clk) begin
        if (in_push) in_mem_q[in_wr_q] <= {wlast_i, wkeep_i, wdata_i[DW-1:0]};
        if (out_push) out_mem_q[out_wr_q] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end

    always_comb begin
        in_wr_d   = in_wr_q;
        in_rd_d   = in_rd_q;
        in_cnt_d  = in_cnt_q;
        out_wr_d  = out_wr_q;
        out_rd_d  = out_rd_q;
        out_cnt_d = out_cnt_q;
        if (flush) begin
            in_wr_d   = '0;
            in_rd_d   = '0;
            in_cnt_d  = '0;
            out_wr_d  = '0;
            out_rd_d  = '0;
            out_cnt_d = '0;
        end else begin
            if (in_push) in_wr_d = in_wr_q + 1'b1;
            if (in_pop)  in_rd_d = in_rd_q + 1'b1;
            if (in_push && !in_pop)      in_cnt_d = in_cnt_q + 1'b1;
            else if (!in_push && in_pop) in_cnt_d = in_cnt_q - 1'b1;
            if (out_push) out_wr_d = out_wr_q + 1'b1;
            if (out_pop)  out_rd_d = out_rd_q + 1'b1;
            if (out_push && !out_pop)      out_cnt_d = out_cnt_q + 1'b1;
            else if (!out_push && out_pop) out_cnt_d = out_cnt_q - 1'b1;
        end
    end

    always_comb begin
        underflow_d   = underflow_q;
        frame_width_d = frame_width_q;
        irq_thresh_d  = irq_thresh_q;
        if (ctrl_wr) begin
            frame_width_d = wdata_i[8:0];
            irq_thresh_d  = wdata_i[23:16];
            if (wdata_i[30]) underflow_d = 1'b0;
        end
        if (rd_data && out_empty) underflow_d = 1'b1;
    end

    // Read data reflects pre-edge state, so same-cycle writes are not yet visible.
    always_comb begin
        rd_word = '0;
        case (raddr_i)
            2'd1: begin
                if (!out_empty) begin
                    rd_word[DW-1:0] = out_head[DW-1:0];
                    rd_word[31]     = out_head[EW-1];
                end
            end
            2'd2: begin
                rd_word[7:0]  = 8'(in_cnt_q);
                rd_word[15:8] = 8'(out_cnt_q);
                rd_word[16]   = in_full;
                rd_word[17]   = out_empty;
                rd_word[18]   = underflow_q;
                rd_word[19]   = !out_empty && out_head[EW-1];
            end
            2'd3: begin
                rd_word[8:0]   = frame_width_q;
                rd_word[23:16] = irq_thresh_q;
            end
            default: rd_word = '0;
        endcase
        rdata_d = ren_i ? AXI_DATA_WIDTH'(rd_word) : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_wr_q       <= '0;
            in_rd_q       <= '0;
            in_cnt_q      <= '0;
            out_wr_q      <= '0;
            out_rd_q      <= '0;
            out_cnt_q     <= '0;
            underflow_q   <= 1'b0;
            frame_width_q <= 9'd128;
            irq_thresh_q  <= 8'd1;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
        end else begin
            in_wr_q       <= in_wr_d;
            in_rd_q       <= in_rd_d;
            in_cnt_q      <= in_cnt_d;
            out_wr_q      <= out_wr_d;
            out_rd_q      <= out_rd_d;
            out_cnt_q     <= out_cnt_d;
            underflow_q   <= underflow_d;
            frame_width_q <= frame_width_d;
            irq_thresh_q  <= irq_thresh_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= ren_i;
        end
    end

`ifdef AOS_BRIDGE_IRQ_EN
    logic irq_q, irq_d;

    // A zero threshold disables the level term; underflow alone can still raise it.
    assign irq_d = ((irq_thresh_q != 8'd0) && (int'(out_cnt_q) >= int'(irq_thresh_q)))
                   || underflow_q;

    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= irq_d;
    end

    assign irq_o = irq_q;

    logic unused_bits;
    assign unused_bits = ^wdata_i;
`else
    assign irq_o = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{wdata_i, irq_thresh_q};
`endif

endmodule

// File: tb/tb_aos_stream_bridge.sv
// Bench for aos_stream_bridge: queue-based reference model compared every cycle,
// plus directed register/stream scenarios with literal expectations.
module tb_aos_stream_bridge;
    localparam int DEPTH = 8;
`ifdef AOS_BRIDGE_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  waddr_i, raddr_i;
    logic [31:0] wdata_i;
    logic [0:0]  wkeep_i;
    logic        wlast_i, wvalid_i, wready_o, ren_i, rvalid_o;
    logic [31:0] rdata_o;
    logic [7:0]  m_axis_tdata, s_axis_tdata;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [0:0]  m_axis_tkeep, s_axis_tkeep;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [8:0]  frame_width_o;
    logic        irq_o;

    always #5 clk = ~clk;

    aos_stream_bridge #(.AXI_DATA_WIDTH(32), .IN_NBYTE(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .waddr_i(waddr_i), .wdata_i(wdata_i), .wkeep_i(wkeep_i), .wlast_i(wlast_i),
        .wvalid_i(wvalid_i), .wready_o(wready_o),
        .raddr_i(raddr_i), .ren_i(ren_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .frame_width_o(frame_width_o), .irq_o(irq_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFOs as queues of {last, keep, data}.
    logic [9:0]  in_q[$];
    logic [9:0]  out_q[$];
    bit          m_uf, m_rvalid, m_irq, started;
    logic [8:0]  m_fw;
    logic [7:0]  m_th;
    logic [31:0] m_rdata;

    always @(posedge clk) begin : model
        logic [31:0] rw;
        bit fl, ipush, ipop, opush, opop, rd_out;
        if (rst) begin
            in_q.delete();
            out_q.delete();
            m_uf = 1'b0; m_fw = 9'd128; m_th = 8'd1;
            m_rdata = 32'd0; m_rvalid = 1'b0; m_irq = 1'b0;
            started = 1'b1;
        end else begin
            m_irq = IRQ_ON && (((m_th != 8'd0) && (out_q.size() >= int'(m_th))) || m_uf);
            m_rvalid = ren_i;
            if (ren_i) begin
                rw = 32'd0;
                case (raddr_i)
                    2'd1: if (out_q.size() > 0) begin
                        rw[7:0] = out_q[0][7:0];
                        rw[31]  = out_q[0][9];
                    end
                    2'd2: begin
                        rw[7:0]  = 8'(in_q.size());
                        rw[15:8] = 8'(out_q.size());
                        rw[16]   = (in_q.size() == DEPTH);
                        rw[17]   = (out_q.size() == 0);
                        rw[18]   = m_uf;
                        rw[19]   = (out_q.size() > 0) && out_q[0][9];
                    end
                    2'd3: begin
                        rw[8:0]   = m_fw;
                        rw[23:16] = m_th;
                    end
                    default: rw = 32'd0;
                endcase
                m_rdata = rw;
            end
            rd_out = ren_i && (raddr_i == 2'd1);
            fl     = wvalid_i && (waddr_i == 2'd3) && wdata_i[31];
            ipush  = wvalid_i && (waddr_i == 2'd0) && (in_q.size() < DEPTH);
            ipop   = (in_q.size() > 0) && m_axis_tready;
            opush  = s_axis_tvalid && (out_q.size() < DEPTH);
            opop   = rd_out && (out_q.size() > 0);
            if (wvalid_i && (waddr_i == 2'd3)) begin
                if (wdata_i[30]) m_uf = 1'b0;
                m_fw = wdata_i[8:0];
                m_th = wdata_i[23:16];
            end
            if (rd_out && (out_q.size() == 0)) m_uf = 1'b1;
            if (fl) begin
                in_q.delete();
                out_q.delete();
            end else begin
                if (ipop)  void'(in_q.pop_front());
                if (ipush) in_q.push_back({wlast_i, wkeep_i, wdata_i[7:0]});
                if (opop)  void'(out_q.pop_front());
                if (opush) out_q.push_back({s_axis_tlast, s_axis_tkeep, s_axis_tdata});
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("wready", 32'(wready_o),
                (waddr_i == 2'd0) ? 32'(in_q.size() < DEPTH) : 32'd1);
            chk("m_tvalid", 32'(m_axis_tvalid), 32'(in_q.size() > 0));
            chk("m_beat", 32'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}),
                (in_q.size() > 0) ? 32'(in_q[0]) : 32'd0);
            chk("s_tready", 32'(s_axis_tready), 32'(out_q.size() < DEPTH));
            chk("frame_width", 32'(frame_width_o), 32'(m_fw));
            chk("rvalid", 32'(rvalid_o), 32'(m_rvalid));
            chk("rdata", rdata_o, m_rdata);
            chk("irq", 32'(irq_o), 32'(m_irq));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic l);
        wvalid_i = 1'b1; waddr_i = a; wdata_i = d; wlast_i = l; wkeep_i = 1'b1;
        cyc();
        wvalid_i = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        ren_i = 1'b1; raddr_i = a;
        cyc();
        ren_i = 1'b0;
        v = rdata_o;
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1;
        waddr_i = 2'd0; raddr_i = 2'd0; wdata_i = 32'd0; wkeep_i = 1'b0; wlast_i = 1'b0;
        wvalid_i = 1'b0; ren_i = 1'b0; m_axis_tready = 1'b0;
        s_axis_tdata = 8'd0; s_axis_tvalid = 1'b0; s_axis_tkeep = 1'b0; s_axis_tlast = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;

        // Reset state
        rd(2'd2, v); chk("rst_status", v, 32'h0002_0000);
        rd(2'd3, v); chk("rst_ctrl", v, 32'h0001_0080);
        rd(2'd0, v); chk("read_reg0", v, 32'h0);

        // Fill the input FIFO while the core stalls, then a blocked ninth write
        for (int i = 0; i < 8; i++) wr(2'd0, 32'h11 + i, (i == 7));
        wvalid_i = 1'b1; waddr_i = 2'd0; wdata_i = 32'h19;
        #1 chk("ninth_wready", 32'(wready_o), 32'd0);
        @(posedge clk); #1;
        wvalid_i = 1'b0;
        rd(2'd2, v); chk("full_status", v, 32'h0003_0008);
        m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_beat", 32'({m_axis_tvalid, m_axis_tdata}), 32'h100 + 32'h11 + i);
            cyc();
        end
        chk("drained", 32'(m_axis_tvalid), 32'd0);

        // Core beat with tlast, read-back and underflow
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'hA5; s_axis_tkeep = 1'b1; s_axis_tlast = 1'b1;
        cyc();
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        rd(2'd2, v); chk("out_status", v, 32'h0008_0100);
        rd(2'd1, v); chk("data_out_a5", v, 32'h8000_00A5);
        rd(2'd1, v); chk("underflow_rd", v, 32'h0);
        rd(2'd2, v); chk("uf_status", v, 32'h0006_0000);
        wr(2'd3, 32'h4001_0080, 1'b0);
        rd(2'd2, v); chk("uf_cleared", v, 32'h0002_0000);

        // Flush with a coincident core handshake and frame width change
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) wr(2'd0, 32'h21 + i, 1'b0);
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'h31; cyc();
        s_axis_tdata = 8'h32; cyc();
        s_axis_tdata = 8'h77;
        wvalid_i = 1'b1; waddr_i = 2'd3; wdata_i = 32'h8001_0040;
        cyc();
        wvalid_i = 1'b0; s_axis_tvalid = 1'b0;
        chk("flush_fw", 32'(frame_width_o), 32'd64);
        rd(2'd2, v); chk("flush_status", v, 32'h0002_0000);
        rd(2'd3, v); chk("ctrl_selfclr", v, 32'h0001_0040);
        m_axis_tready = 1'b1;

        // Full throughput: push/pop on both FIFOs every cycle
        for (int i = 0; i < 4; i++) begin
            wvalid_i = 1'b1; waddr_i = 2'd0; wdata_i = 32'h41 + i; wlast_i = 1'b0; wkeep_i = 1'b1;
            s_axis_tvalid = 1'b1; s_axis_tdata = 8'(8'h81 + i);
            ren_i = (i > 0); raddr_i = 2'd1;
            cyc();
            if (i > 0) chk("stream_rd", rdata_o, 32'h80 + i);
        end
        wvalid_i = 1'b0; s_axis_tvalid = 1'b0;
        cyc();
        ren_i = 1'b0;
        chk("stream_rd_last", rdata_o, 32'h84);

        // Output-level interrupt with threshold 2
        wr(2'd3, 32'h0002_0040, 1'b0);
        s_axis_tvalid = 1'b1; s_axis_tdata = 8'h51; cyc();
        s_axis_tdata = 8'h52; cyc();
        s_axis_tvalid = 1'b0;
        chk("irq_pre", 32'(irq_o), 32'd0);
        cyc();
        chk("irq_rise", 32'(irq_o), 32'(IRQ_ON));
        rd(2'd1, v); chk("irq_pop1", v, 32'h51);
        chk("irq_hold", 32'(irq_o), 32'(IRQ_ON));
        cyc();
        chk("irq_fall", 32'(irq_o), 32'd0);
        rd(2'd1, v); chk("irq_pop2", v, 32'h52);

        // Same-cycle CTRL write and CTRL read; ignored writes
        wvalid_i = 1'b1; waddr_i = 2'd3; wdata_i = 32'h0005_0100;
        ren_i = 1'b1; raddr_i = 2'd3;
        cyc();
        wvalid_i = 1'b0; ren_i = 1'b0;
        chk("ctrl_pre_write", rdata_o, 32'h0002_0040);
        rd(2'd3, v); chk("ctrl_post_write", v, 32'h0005_0100);
        wr(2'd2, 32'hFFFF_FFFF, 1'b1);
        wr(2'd1, 32'hFFFF_FFFF, 1'b1);
        rd(2'd2, v); chk("ignored_wr", v, 32'h0002_0000);

        // Reset during a stalled transfer
        m_axis_tready = 1'b0;
        wr(2'd0, 32'h61, 1'b0);
        wr(2'd0, 32'h62, 1'b1);
        chk("stall_valid", 32'(m_axis_tvalid), 32'd1);
        rst = 1'b1;
        cyc();
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        rst = 1'b0;
        chk("rst_fw", 32'(frame_width_o), 32'd128);
        rd(2'd2, v); chk("rst_mid_status", v, 32'h0002_0000);
        rd(2'd3, v); chk("rst_mid_ctrl", v, 32'h0001_0080);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
